// File: rtl/perceptron_trainer.sv
`default_nettype none
// ============================================================================
// Module      : perceptron_trainer
// Description : Sample sequencing, thresholding and saturating perceptron-rule
//               weight/bias update around an external weighted-sum pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module perceptron_trainer #(
    parameter int N           = 8,
    parameter int SUM_LATENCY = 11,
    parameter int ETA_SHIFT   = 4,
    parameter int BIAS_STEP   = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_valid,
    output logic            sample_ready,
    input  logic [18*N-1:0] x_in,
    input  logic            target,
    input  logic            train_en,
    output logic [18*N-1:0] x_out,
    output logic [18*N-1:0] w_out,
    input  logic [47:0]     sum_in,
    output logic            result_valid,
    output logic            result,
    output logic            mistake,
    output logic [15:0]     err_count
);

    localparam int                     c_CNT_W     = (SUM_LATENCY > 1) ? $clog2(SUM_LATENCY) : 1;
    localparam logic [c_CNT_W-1:0]     c_CNT_LOAD  = c_CNT_W'(SUM_LATENCY - 1);
    localparam logic signed [18:0]     c_SAT_MAX   = 19'sd131071;
    localparam logic signed [18:0]     c_SAT_MIN   = -19'sd131072;
    localparam logic signed [18:0]     c_BIAS_STEP = 19'(BIAS_STEP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_EVAL = 2'd2
    } state_t;

    function automatic logic signed [17:0] sat18(input logic signed [18:0] v);
        if (v > c_SAT_MAX) begin
            return 18'sh1FFFF;
        end else if (v < c_SAT_MIN) begin
            return 18'sh20000;
        end
        return v[17:0];
    endfunction

    state_t                 r_state_q, w_state_d;
    logic [c_CNT_W-1:0]     r_cnt_q, w_cnt_d;
    logic [18*N-1:0]        r_x_q, w_x_d;
    logic                   r_target_q, w_target_d;
    logic                   r_train_q, w_train_d;
    logic signed [17:0]     r_w_q [N];
    logic signed [17:0]     w_w_d [N];
    logic signed [17:0]     r_bias_q, w_bias_d;
    logic                   r_result_valid_q, w_result_valid_d;
    logic                   r_result_q, w_result_d;
    logic                   r_mistake_q, w_mistake_d;
    logic [15:0]            r_err_q, w_err_d;

    logic signed [17:0]     w_inc [N];
    logic signed [17:0]     w_dec [N];
    logic signed [18:0]     w_bias_ext;
    logic signed [17:0]     w_bias_inc, w_bias_dec;
    logic [48:0]            w_thresh;
    logic                   w_pred;
    logic                   w_miss;

    // Per-lane update candidates: both directions are ready, the FSM picks one.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic signed [18:0] w_x_ext;
            logic signed [18:0] w_wt_ext;
            logic signed [18:0] w_delta;
            assign w_x_ext             = {r_x_q[18*gi+17], r_x_q[18*gi +: 18]};
            assign w_wt_ext            = {r_w_q[gi][17], r_w_q[gi]};
            assign w_delta             = w_x_ext >>> ETA_SHIFT;
            assign w_inc[gi]           = sat18(w_wt_ext + w_delta);
            assign w_dec[gi]           = sat18(w_wt_ext - w_delta);
            assign w_out[18*gi +: 18]  = r_w_q[gi];
        end
    endgenerate

    assign w_bias_ext = {r_bias_q[17], r_bias_q};
    assign w_bias_inc = sat18(w_bias_ext + c_BIAS_STEP);
    assign w_bias_dec = sat18(w_bias_ext - c_BIAS_STEP);

    // 49-bit compare so sum + bias can never overflow into the sign bit.
    assign w_thresh = {sum_in[47], sum_in} + {{31{r_bias_q[17]}}, r_bias_q};
    assign w_pred   = ~w_thresh[48];
    assign w_miss   = (w_pred != r_target_q);

    always_comb begin
        w_state_d        = r_state_q;
        w_cnt_d          = r_cnt_q;
        w_x_d            = r_x_q;
        w_target_d       = r_target_q;
        w_train_d        = r_train_q;
        w_w_d            = r_w_q;
        w_bias_d         = r_bias_q;
        w_result_valid_d = 1'b0;
        w_result_d       = r_result_q;
        w_mistake_d      = r_mistake_q;
        w_err_d          = r_err_q;
        case (r_state_q)
            S_IDLE: begin
                if (sample_valid) begin
                    w_x_d      = x_in;
                    w_target_d = target;
                    w_train_d  = train_en;
                    w_cnt_d    = c_CNT_LOAD;
                    w_state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt_q == '0) begin
                    w_state_d = S_EVAL;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_W'(1);
                end
            end
            S_EVAL: begin
                w_result_d       = w_pred;
                w_mistake_d      = w_miss;
                w_result_valid_d = 1'b1;
                w_state_d        = S_IDLE;
                if (w_miss && (r_err_q != 16'hFFFF)) begin
                    w_err_d = r_err_q + 16'd1;
                end
                if (w_miss && r_train_q) begin
                    for (int i = 0; i < N; i++) begin
                        w_w_d[i] = r_target_q ? w_inc[i] : w_dec[i];
                    end
                    w_bias_d = r_target_q ? w_bias_inc : w_bias_dec;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q        <= S_IDLE;
            r_cnt_q          <= '0;
            r_x_q            <= '0;
            r_target_q       <= 1'b0;
            r_train_q        <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_w_q[i] <= '0;
            end
            r_bias_q         <= '0;
            r_result_valid_q <= 1'b0;
            r_result_q       <= 1'b0;
            r_mistake_q      <= 1'b0;
            r_err_q          <= '0;
        end else begin
            r_state_q        <= w_state_d;
            r_cnt_q          <= w_cnt_d;
            r_x_q            <= w_x_d;
            r_target_q       <= w_target_d;
            r_train_q        <= w_train_d;
            r_w_q            <= w_w_d;
            r_bias_q         <= w_bias_d;
            r_result_valid_q <= w_result_valid_d;
            r_result_q       <= w_result_d;
            r_mistake_q      <= w_mistake_d;
            r_err_q          <= w_err_d;
        end
    end

    assign sample_ready = (r_state_q == S_IDLE);
    assign x_out        = r_x_q;
    assign result_valid = r_result_valid_q;
    assign result       = r_result_q;
    assign mistake      = r_mistake_q;
    assign err_count    = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_perceptron_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_perceptron_trainer
// Description : Scoreboard bench for perceptron_trainer with a behavioural
//               weighted-sum pipeline and an arithmetic perceptron model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron_trainer;

    localparam int     N     = 8;
    localparam int     L     = 11;
    localparam int     ETA   = 4;
    localparam int     BSTEP = 256;
    localparam int     W     = 18 * N;
    localparam longint BIG   = 64'sd1099511627776;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_valid = 1'b0;
    logic          sample_ready;
    logic [W-1:0]  x_in = '0;
    logic          target = 1'b0;
    logic          train_en = 1'b0;
    logic [W-1:0]  x_out;
    logic [W-1:0]  w_out;
    logic [47:0]   sum_in;
    logic          result_valid;
    logic          result;
    logic          mistake;
    logic [15:0]   err_count;

    logic          force_mode = 1'b0;
    longint        force_val = 0;
    logic [47:0]   pipe [L];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        bit           pred;
        bit           mis;
        int           err;
        logic [W-1:0] w;
        int           acc;
    } exp_t;
    exp_t sb[$];
    exp_t me;

    int mw[N];
    int mb;
    int merr;
    int stim_x[N];
    int last_acc = 0;
    bit in_burst = 1'b0;

    perceptron_trainer #(
        .N(N), .SUM_LATENCY(L), .ETA_SHIFT(ETA), .BIAS_STEP(BSTEP)
    ) dut (
        .clk(clk), .rst(rst),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .x_in(x_in), .target(target), .train_en(train_en),
        .x_out(x_out), .w_out(w_out), .sum_in(sum_in),
        .result_valid(result_valid), .result(result), .mistake(mistake),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic longint dot_bus(input logic [W-1:0] xb, input logic [W-1:0] wb);
        longint s = 0;
        for (int i = 0; i < N; i++) begin
            s += longint'($signed(xb[18*i +: 18])) * longint'($signed(wb[18*i +: 18]));
        end
        return s;
    endfunction

    // Downstream weighted-sum stage: dot product seen L cycles later.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        pipe[0] <= 48'(dot_bus(x_out, w_out));
        for (int i = 1; i < L; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign sum_in = force_mode ? force_val[47:0] : pipe[L-1];

    function automatic int clamp18(input int v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic logic [W-1:0] pack_w();
        logic [W-1:0] pw;
        for (int i = 0; i < N; i++) begin
            pw[18*i +: 18] = 18'(mw[i]);
        end
        return pw;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mw[i] = 0;
        mb   = 0;
        merr = 0;
    endtask

    task automatic rand_x(input int lo, input int hi);
        for (int i = 0; i < N; i++) begin
            stim_x[i] = int'($urandom_range(hi - lo)) + lo;
        end
    endtask

    task automatic send(input bit tgt, input bit trn, input bit fm, input longint fv, input bit push);
        int     n;
        exp_t   e;
        longint s;
        bit     p;
        bit     mis;
        int     sgn;
        n = 0;
        @(negedge clk);
        while (sample_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: sample_ready=%b expected 1", sample_ready);
            return;
        end
        for (int i = 0; i < N; i++) x_in[18*i +: 18] = 18'(stim_x[i]);
        target       = tgt;
        train_en     = trn;
        force_mode   = fm;
        force_val    = fv;
        sample_valid = 1'b1;
        if (in_burst) chk("accept_gap", longint'(cyc - last_acc), 64'sd13);
        last_acc = cyc;
        in_burst = 1'b1;
        if (push) begin
            s = 0;
            if (fm) s = fv;
            else for (int i = 0; i < N; i++) s += longint'(stim_x[i]) * longint'(mw[i]);
            p   = (s + longint'(mb)) >= 0;
            mis = (p != tgt);
            if (mis && merr < 65535) merr++;
            if (mis && trn) begin
                sgn = tgt ? 1 : -1;
                for (int i = 0; i < N; i++) mw[i] = clamp18(mw[i] + sgn * (stim_x[i] >>> ETA));
                mb = clamp18(mb + sgn * BSTEP);
            end
            e.pred = p;
            e.mis  = mis;
            e.err  = merr;
            e.w    = pack_w();
            e.acc  = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        // Garbage while busy: must be ignored until the next IDLE cycle.
        for (int i = 0; i < N; i++) x_in[18*i +: 18] = 18'($urandom);
        target   = 1'($urandom);
        train_en = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        sample_valid = 1'b0;
        in_burst     = 1'b0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && result_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result_valid: got 1 at cycle %0d expected 0", cyc);
                end else begin
                    me = sb.pop_front();
                    chk("result", longint'(result), longint'(me.pred));
                    chk("mistake", longint'(mistake), longint'(me.mis));
                    chk("err_count", longint'(err_count), longint'(me.err));
                    chkw("w_out", w_out, me.w);
                    chk("latency", longint'(cyc - me.acc), 64'sd13);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("rst_ready", longint'(sample_ready), 64'sd1);
            chkw("rst_w_out", w_out, '0);
            chk("rst_err", longint'(err_count), 64'sd0);
            chk("rst_valid", longint'(result_valid), 64'sd0);
        end
        chkw("rst_x_out", x_out, '0);

        // Single-feature mistake, then the corrected repeat, then no-train mistake.
        for (int i = 0; i < N; i++) stim_x[i] = 0;
        stim_x[0] = 4096;
        send(1'b0, 1'b1, 1'b0, 0, 1'b1);
        drain();
        chk("case1_w0", longint'(w_out[17:0]), longint'(18'h3FF00));
        chkw("case1_w_rest", {18'h0, w_out[W-1:18]}, '0);
        chk("case1_err", longint'(err_count), 64'sd1);
        send(1'b0, 1'b1, 1'b0, 0, 1'b1);
        drain();
        chk("case2_w0", longint'(w_out[17:0]), longint'(18'h3FF00));
        chk("case2_err", longint'(err_count), 64'sd1);
        send(1'b1, 1'b0, 1'b0, 0, 1'b1);
        drain();
        chk("case3_w0", longint'(w_out[17:0]), longint'(18'h3FF00));
        chk("case3_err", longint'(err_count), 64'sd2);

        // Threshold boundary: sum + bias == 0 counts as positive.
        send(1'b0, 1'b0, 1'b1, 64'sd256, 1'b1);
        send(1'b0, 1'b0, 1'b1, 64'sd255, 1'b1);
        drain();

        // Forced mistakes drive weights and bias into their positive limit.
        for (int k = 0; k < 560; k++) begin
            rand_x(16384, 131071);
            send(1'b1, 1'b1, 1'b1, -BIG, 1'b1);
        end
        drain();
        for (int i = 0; i < N; i++) chk("sat_hi_w", longint'(w_out[18*i +: 18]), longint'(18'h1FFFF));
        send(1'b1, 1'b0, 1'b1, -64'sd131071, 1'b1);
        send(1'b1, 1'b0, 1'b1, -64'sd131072, 1'b1);
        drain();

        for (int k = 0; k < 1100; k++) begin
            rand_x(16384, 131071);
            send(1'b0, 1'b1, 1'b1, BIG, 1'b1);
        end
        drain();
        for (int i = 0; i < N; i++) chk("sat_lo_w", longint'(w_out[18*i +: 18]), longint'(18'h20000));
        send(1'b0, 1'b0, 1'b1, 64'sd131072, 1'b1);
        send(1'b0, 1'b0, 1'b1, 64'sd131071, 1'b1);
        drain();

        // Random samples through the real weighted-sum model.
        for (int k = 0; k < 300; k++) begin
            rand_x(-131072, 131071);
            send(1'($urandom), 1'($urandom), 1'b0, 0, 1'b1);
            if ($urandom_range(9) == 0) drain();
        end
        drain();

        // Reset mid-flight: sample discarded, everything back to reset values.
        rand_x(-131072, 131071);
        send(1'b1, 1'b1, 1'b0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst          = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ready", longint'(sample_ready), 64'sd1);
        chkw("mid_rst_w_out", w_out, '0);
        chkw("mid_rst_x_out", x_out, '0);
        chk("mid_rst_err", longint'(err_count), 64'sd0);
        chk("mid_rst_valid", longint'(result_valid), 64'sd0);
        rst = 1'b0;
        model_reset();
        in_burst = 1'b0;
        repeat (20) @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            rand_x(-131072, 131071);
            send(1'($urandom), 1'b1, 1'b0, 0, 1'b1);
        end
        drain();
        chk("sb_empty", longint'(sb.size()), 64'sd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
